// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the elastic pipeline buffer: the stage payload
// structs that travel through each buffer instance as flat vectors, and
// their widths for use as the DATA_W parameter.
package pipe_stage_buf_pkg;

   // Width of the occupancy output (counts 0..2 held beats).
   localparam int OCC_W = 2;

   // The halt flag sits in bit 0 of every stage struct so HALT_BIT=0
   // works for all four buffer instances.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        halt;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
      logic        halt;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_val;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
      logic        halt;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_val;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        halt;
   } mem_wb_t;

   localparam int IF_ID_W  = $bits(if_id_t);
   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);
   localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
// The producer side uses the master modport, the consumer side the slave.
interface pipe_stage_buf_if #(
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_slot.sv
// One storage element of the buffer: a valid bit plus payload.
// clear wins over load; zero_data lets a clear also wipe the payload so a
// flushed slot reads back as an all-zero bubble.
module pipe_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic              zero_data,
   input  logic [DATA_W-1:0] din,
   output logic              vld,
   output logic [DATA_W-1:0] dat
);

   // Slot register: reset, then clear, then load; otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= 1'b0;
         dat <= '0;
      end else if (clear) begin
         vld <= 1'b0;
         if (zero_data) begin
            dat <= '0;
         end
      end else if (load) begin
         vld <= 1'b1;
         dat <= din;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer placed between two pipeline stages. Holds one
// beat in the main slot, optionally a second beat in a skid slot so that
// in_ready can be registered. Supports flush (optionally zeroing held data),
// sticky halt capture and a saturating stall counter.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int SKID         = 1,
   parameter int CLR_ON_FLUSH = 1,
   parameter int HALT_EN      = 1,
   parameter int HALT_BIT     = 0,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   pipe_stage_buf_if.slave  up,
   pipe_stage_buf_if.master dn,
   output logic             halted,
   output logic [OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0] stall_cycles
);

   logic              in_ready;
   logic              in_fire;
   logic              out_fire;
   logic              vld_m;
   logic              vld_s;
   logic [DATA_W-1:0] dat_m;
   logic [DATA_W-1:0] din_m;
   logic              load_m;
   logic              clr_m;
   logic              zero_flush;

   assign in_fire    = up.valid && in_ready;
   assign out_fire   = vld_m && dn.ready;
   assign zero_flush = flush && (CLR_ON_FLUSH != 0);

   assign up.ready  = in_ready;
   assign dn.valid  = vld_m;
   assign dn.data   = dat_m;
   assign occupancy = OCC_W'(vld_m) + OCC_W'(vld_s);

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (load_m),
      .clear     (clr_m),
      .zero_data (zero_flush),
      .din       (din_m),
      .vld       (vld_m),
      .dat       (dat_m)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic              load_s;
         logic              clr_s;
         logic [DATA_W-1:0] dat_s;

         // Ready depends only on registered state, so out_ready never
         // reaches in_ready combinationally.
         assign in_ready = !reset && !halted && !vld_s;

         pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clk       (clk),
            .reset     (reset),
            .load      (load_s),
            .clear     (clr_s),
            .zero_data (zero_flush),
            .din       (up.data),
            .vld       (vld_s),
            .dat       (dat_s)
         );

         // Slot steering: a held skid beat always moves to main before any
         // new beat, so ordering is preserved.
         always_comb begin
            load_m = 1'b0;
            clr_m  = 1'b0;
            din_m  = up.data;
            load_s = 1'b0;
            clr_s  = 1'b0;
            if (flush) begin
               clr_m = 1'b1;
               clr_s = 1'b1;
            end else if (!vld_m) begin
               load_m = in_fire;
            end else if (out_fire) begin
               if (vld_s) begin
                  load_m = 1'b1;
                  din_m  = dat_s;
                  clr_s  = 1'b1;
               end else if (in_fire) begin
                  load_m = 1'b1;
               end else begin
                  clr_m = 1'b1;
               end
            end else if (in_fire) begin
               load_s = 1'b1;
            end
         end
      end else begin : g_single
         assign vld_s = 1'b0;

         // Single slot: accept whenever the slot is empty or draining now.
         assign in_ready = !reset && !halted && (!vld_m || dn.ready);

         // Main slot steering for the single-slot variant.
         always_comb begin
            load_m = 1'b0;
            clr_m  = 1'b0;
            din_m  = up.data;
            if (flush) begin
               clr_m = 1'b1;
            end else if (in_fire) begin
               load_m = 1'b1;
            end else if (out_fire) begin
               clr_m = 1'b1;
            end
         end
      end
   endgenerate

   // Sticky halt: set by an accepted halt beat (unless flushed), cleared by reset only.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted <= 1'b0;
      end else if ((HALT_EN != 0) && !flush && in_fire && up.data[HALT_BIT]) begin
         halted <= 1'b1;
      end
   end

   // Stall counter: counts cycles with a held beat refused downstream, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (vld_m && !dn.ready && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   a_skid_needs_main : assert property (@(posedge clk) disable iff (reset)
      !vld_m |-> !vld_s);

   a_single_occ : assert property (@(posedge clk) disable iff (reset)
      (SKID == 0) |-> (occupancy <= OCC_W'(1)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf. Three instances share one stimulus:
// a: SKID=1, no halt;  b: SKID=0, CNT_W=4, no halt;  c: SKID=1, halt on bit 0.
module tb_pipe_stage_buf;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        halt_a, halt_b, halt_c;
   logic [1:0]  occ_a, occ_b, occ_c;
   logic [15:0] stall_a, stall_c;
   logic [3:0]  stall_b;

   int n_checks;
   int n_errors;

   pipe_stage_buf_if #(.DATA_W(32)) up_a ();
   pipe_stage_buf_if #(.DATA_W(32)) dn_a ();
   pipe_stage_buf_if #(.DATA_W(32)) up_b ();
   pipe_stage_buf_if #(.DATA_W(32)) dn_b ();
   pipe_stage_buf_if #(.DATA_W(32)) up_c ();
   pipe_stage_buf_if #(.DATA_W(32)) dn_c ();

   assign up_a.valid = in_valid;
   assign up_a.data  = in_data;
   assign dn_a.ready = out_ready;
   assign up_b.valid = in_valid;
   assign up_b.data  = in_data;
   assign dn_b.ready = out_ready;
   assign up_c.valid = in_valid;
   assign up_c.data  = in_data;
   assign dn_c.ready = out_ready;

   pipe_stage_buf #(.DATA_W(32), .SKID(1), .CLR_ON_FLUSH(1), .HALT_EN(0),
                    .HALT_BIT(0), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .flush(flush), .up(up_a), .dn(dn_a),
      .halted(halt_a), .occupancy(occ_a), .stall_cycles(stall_a));

   pipe_stage_buf #(.DATA_W(32), .SKID(0), .CLR_ON_FLUSH(1), .HALT_EN(0),
                    .HALT_BIT(0), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .up(up_b), .dn(dn_b),
      .halted(halt_b), .occupancy(occ_b), .stall_cycles(stall_b));

   pipe_stage_buf #(.DATA_W(32), .SKID(1), .CLR_ON_FLUSH(1), .HALT_EN(1),
                    .HALT_BIT(0), .CNT_W(16)) dut_c (
      .clk(clk), .reset(reset), .flush(flush), .up(up_c), .dn(dn_c),
      .halted(halt_c), .occupancy(occ_c), .stall_cycles(stall_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock: return 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Two reset cycles with idle inputs, reset released afterwards.
   task automatic do_reset();
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;

      // ---- reset state and throughput (a) ----
      cyc();
      check("rst_in_ready", 32'(up_a.ready), 32'd0);
      check("rst_out_valid", 32'(dn_a.valid), 32'd0);
      cyc();
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(up_a.ready), 32'd1);
      check("post_rst_occ", 32'(occ_a), 32'd0);
      in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
      cyc();
      in_data = 32'h22;
      #1;
      check("tp_d0", dn_a.data, 32'h11);
      check("tp_occ0", 32'(occ_a), 32'd1);
      cyc();
      in_data = 32'h33;
      #1;
      check("tp_d1", dn_a.data, 32'h22);
      cyc();
      in_valid = 1'b0;
      #1;
      check("tp_d2", dn_a.data, 32'h33);
      check("tp_v2", 32'(dn_a.valid), 32'd1);
      check("tp_occ2", 32'(occ_a), 32'd1);
      cyc();
      check("tp_drained", 32'(dn_a.valid), 32'd0);
      check("tp_stall", 32'(stall_a), 32'd0);

      // ---- backpressure, skid (a) ----
      do_reset();
      in_valid = 1'b1; in_data = 32'hA1;
      cyc();
      in_data = 32'hA2;
      #1;
      check("bp_ready_skid_free", 32'(up_a.ready), 32'd1);
      check("bp_stall0", 32'(stall_a), 32'd0);
      cyc();
      in_data = 32'hA3;
      #1;
      check("bp_occ2", 32'(occ_a), 32'd2);
      check("bp_ready_full", 32'(up_a.ready), 32'd0);
      check("bp_stall1", 32'(stall_a), 32'd1);
      check("bp_head", dn_a.data, 32'hA1);
      cyc();
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("bp_stall2", 32'(stall_a), 32'd2);
      check("bp_occ_hold", 32'(occ_a), 32'd2);
      check("bp_out_a1", dn_a.data, 32'hA1);
      cyc();
      check("bp_out_a2", dn_a.data, 32'hA2);
      check("bp_occ1", 32'(occ_a), 32'd1);
      check("bp_stall_keep", 32'(stall_a), 32'd2);
      cyc();
      check("bp_empty_v", 32'(dn_a.valid), 32'd0);
      check("bp_empty_occ", 32'(occ_a), 32'd0);

      // ---- backpressure, single slot (b) ----
      do_reset();
      in_valid = 1'b1; in_data = 32'hA1;
      cyc();
      in_data = 32'hA2;
      #1;
      check("ss_ready_low", 32'(up_b.ready), 32'd0);
      check("ss_occ1", 32'(occ_b), 32'd1);
      out_ready = 1'b1;
      #1;
      check("ss_ready_comb", 32'(up_b.ready), 32'd1);
      out_ready = 1'b0;
      #1;
      cyc();
      check("ss_hold_a1", dn_b.data, 32'hA1);
      check("ss_occ_max1", 32'(occ_b), 32'd1);
      check("ss_stall1", 32'(stall_b), 32'd1);
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      #1;
      check("ss_out_a2", dn_b.data, 32'hA2);
      check("ss_v_a2", 32'(dn_b.valid), 32'd1);
      cyc();
      check("ss_empty", 32'(dn_b.valid), 32'd0);
      check("ss_empty_occ", 32'(occ_b), 32'd0);

      // ---- flush with full buffer (a) ----
      do_reset();
      in_valid = 1'b1; in_data = 32'hB1;
      cyc();
      in_data = 32'hB2;
      cyc();
      in_data = 32'hB3; flush = 1'b1;
      #1;
      check("fl_occ_before", 32'(occ_a), 32'd2);
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("fl_valid", 32'(dn_a.valid), 32'd0);
      check("fl_occ", 32'(occ_a), 32'd0);
      check("fl_data_zero", dn_a.data, 32'h0);
      out_ready = 1'b1;
      cyc();
      check("fl_b3_gone", 32'(dn_a.valid), 32'd0);
      check("fl_ready", 32'(up_a.ready), 32'd1);

      // ---- halt (c) ----
      do_reset();
      in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
      #1;
      check("ht_ready_pre", 32'(up_c.ready), 32'd1);
      cyc();
      in_data = 32'h6;
      #1;
      check("ht_halted", 32'(halt_c), 32'd1);
      check("ht_ready_low", 32'(up_c.ready), 32'd0);
      check("ht_out5", dn_c.data, 32'h5);
      check("ht_v5", 32'(dn_c.valid), 32'd1);
      cyc();
      check("ht_6_blocked", 32'(dn_c.valid), 32'd0);
      cyc();
      check("ht_6_blocked2", 32'(occ_c), 32'd0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      check("ht_flush_keeps", 32'(halt_c), 32'd1);
      in_valid = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      check("ht_reset_clears", 32'(halt_c), 32'd0);
      check("ht_ready_back", 32'(up_c.ready), 32'd1);

      // ---- stall counter saturation (b, CNT_W=4) ----
      do_reset();
      in_valid = 1'b1; in_data = 32'h40;
      cyc();
      in_valid = 1'b0;
      #1;
      check("sat_start", 32'(stall_b), 32'd0);
      repeat (5) cyc();
      check("sat_mid", 32'(stall_b), 32'd5);
      repeat (15) cyc();
      check("sat_cap", 32'(stall_b), 32'd15);
      check("sat_still_held", dn_b.data, 32'h40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
